// File: rtl/nes_pkg.sv
// Shared NES serial-controller definitions: button bit positions, frame width
// and the responder/reader FSM state encoding.
package nes_pkg;

  localparam int unsigned NES_BITS  = 8;

  localparam int unsigned BTN_A     = 0;
  localparam int unsigned BTN_B     = 1;
  localparam int unsigned BTN_SEL   = 2;
  localparam int unsigned BTN_START = 3;
  localparam int unsigned BTN_UP    = 4;
  localparam int unsigned BTN_DOWN  = 5;
  localparam int unsigned BTN_LEFT  = 6;
  localparam int unsigned BTN_RIGHT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } nes_state_t;

endpackage

// File: rtl/nes_controller_emulator_if.sv
// NES controller link: latch and shift clock from the reader/console,
// active-low serial data back from the controller.
interface nes_controller_emulator_if;
  logic latchOrange;
  logic clockRed;
  logic dataYellow;

  modport master (output latchOrange, output clockRed, input dataYellow);
  modport slave  (input latchOrange, input clockRed, output dataYellow);
endinterface

// File: rtl/nes_controller_emulator_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, followed by an edge
// detect flop producing single-cycle rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/nes_controller_emulator.sv
// NES controller responder: captures buttons while latch is high and shifts
// them out active-low, one per clock pulse. Optional turbo via NES_TURBO_EN.
module nes_controller_emulator
  import nes_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURBO_DIV   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  nes_controller_emulator_if.slave nes,
  input  logic [NES_BITS-1:0]      buttons,
  input  logic                     turboA,
  input  logic                     turboB,
  output logic                     frameStrobe,
  output logic                     busy
);

  logic latch_rise, latch_fall, clk_rise, clk_fall_unused;
  logic latch_fall_unused_guard;

  sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clock_i (clock),
    .reset_i (reset),
    .async_i (nes.latchOrange),
    .rise_o  (latch_rise),
    .fall_o  (latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_clock_sync (
    .clock_i (clock),
    .reset_i (reset),
    .async_i (nes.clockRed),
    .rise_o  (clk_rise),
    .fall_o  (clk_fall_unused)
  );

  assign latch_fall_unused_guard = 1'b0;

  nes_state_t          state_q, state_d;
  logic [NES_BITS-1:0] shift_q, shift_d;
  logic [3:0]          count_q, count_d;
  logic                data_q, data_d;
  logic                strobe_q, strobe_d;
  logic [NES_BITS-1:0] eff_buttons;
  logic                frame_fall;

  // A frame closes only on a latch fall seen in LOAD that no latch rise overrides.
  assign frame_fall = (state_q == LOAD) && latch_fall && !latch_rise;

`ifdef NES_TURBO_EN
  localparam int unsigned TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          phase_q, phase_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    if (frame_fall) begin
      if (tcnt_q == TW'(TURBO_DIV - 1)) begin
        tcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    eff_buttons        = buttons;
    eff_buttons[BTN_A] = buttons[BTN_A] & (~turboA | phase_q);
    eff_buttons[BTN_B] = buttons[BTN_B] & (~turboB | phase_q);
  end
`else
  localparam int unsigned unused_turbo_div = TURBO_DIV;
  logic unused_turbo;
  assign unused_turbo = turboA ^ turboB;

  always_comb begin
    eff_buttons = buttons;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      count_q  <= '0;
      data_q   <= 1'b1;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    // Latch rise pre-empts everything, including a coincident clock rise.
    if (latch_rise) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          shift_d = eff_buttons;
          if (latch_fall) begin
            state_d = SHIFT;
            count_d = '0;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            shift_d = {1'b0, shift_q[NES_BITS-1:1]};
            count_d = count_q + 4'd1;
            if (count_q == 4'd7) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_d   = 1'b1;
    strobe_d = frame_fall | latch_fall_unused_guard;
    case (state_q)
      LOAD:    data_d = ~eff_buttons[BTN_A];
      SHIFT:   data_d = ~shift_q[0];
      default: data_d = 1'b1;
    endcase
  end

  logic unused_clk_fall;
  assign unused_clk_fall = clk_fall_unused;

  assign nes.dataYellow = data_q;
  assign frameStrobe    = strobe_q;
  assign busy           = (state_q == LOAD) || (state_q == SHIFT);

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Directed bench for the NES controller responder: table of button frames
// plus hand-written live-tracking, abort, coincident-edge, reset and turbo sequences.
module tb_nes_controller_emulator;

  localparam int unsigned HALF       = 8;
  localparam int unsigned LATCH_HOLD = 12;
  localparam int unsigned SETTLE     = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] buttons;
  logic       turboA, turboB;
  logic       frameStrobe, busy;

  int checks   = 0;
  int failures = 0;
  int strobe_cnt  = 0;
  int strobe_wide = 0;
  logic strobe_prev = 1'b0;

  nes_controller_emulator_if nes ();

  nes_controller_emulator #(
    .SYNC_STAGES (2),
    .TURBO_DIV   (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .nes         (nes),
    .buttons     (buttons),
    .turboA      (turboA),
    .turboB      (turboB),
    .frameStrobe (frameStrobe),
    .busy        (busy)
  );

  always #10 clock = ~clock;

  always @(posedge clock) begin
    if (frameStrobe) strobe_cnt++;
    if (frameStrobe && strobe_prev) strobe_wide++;
    strobe_prev = frameStrobe;
  end

  typedef struct {
    logic [7:0] btn;
    logic [7:0] exp;  // bit k = expected dataYellow at read k
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic latch_pulse();
    @(negedge clock);
    nes.latchOrange = 1'b1;
    wait_cycles(LATCH_HOLD);
    nes.latchOrange = 1'b0;
    wait_cycles(SETTLE);
  endtask

  task automatic clk_pulse();
    @(negedge clock);
    nes.clockRed = 1'b1;
    wait_cycles(HALF);
    nes.clockRed = 1'b0;
    wait_cycles(HALF);
  endtask

  task automatic read_frame(input logic [7:0] exp, input string tag);
    latch_pulse();
    check($sformatf("%s_bit0", tag), {31'd0, nes.dataYellow}, {31'd0, exp[0]});
    check($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      clk_pulse();
      check($sformatf("%s_bit%0d", tag, k), {31'd0, nes.dataYellow}, {31'd0, exp[k]});
    end
    clk_pulse();
    check($sformatf("%s_after8", tag), {31'd0, nes.dataYellow}, 32'd1);
    clk_pulse();
    check($sformatf("%s_ninth", tag), {31'd0, nes.dataYellow}, 32'd1);
    check($sformatf("%s_done_busy", tag), {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(3);
  endtask

  initial begin
    int s0;
    logic turbo_exp;

    vecs[0] = '{btn: 8'h09, exp: 8'b1111_0110};
    vecs[1] = '{btn: 8'h00, exp: 8'hFF};
    vecs[2] = '{btn: 8'hFF, exp: 8'h00};
    vecs[3] = '{btn: 8'hA5, exp: 8'h5A};
    vecs[4] = '{btn: 8'h80, exp: 8'h7F};

    reset = 1'b1;
    nes.latchOrange = 1'b0;
    nes.clockRed = 1'b0;
    buttons = 8'h00;
    turboA = 1'b0;
    turboB = 1'b0;
    wait_cycles(5);
    check("reset_data", {31'd0, nes.dataYellow}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_strobe", {31'd0, frameStrobe}, 32'd0);
    reset = 1'b0;
    wait_cycles(50);
    check("idle_data", {31'd0, nes.dataYellow}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_strobes", strobe_cnt, 32'd0);

    // Table-driven full frames
    for (int i = 0; i < 5; i++) begin
      buttons = vecs[i].btn;
      s0 = strobe_cnt;
      read_frame(vecs[i].exp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, 32'd1);
    end

    // Live tracking while latch high, frozen after latch fall
    buttons = 8'h00;
    @(negedge clock);
    nes.latchOrange = 1'b1;
    wait_cycles(10);
    check("live_released", {31'd0, nes.dataYellow}, 32'd1);
    buttons = 8'h01;
    wait_cycles(4);
    check("live_pressed", {31'd0, nes.dataYellow}, 32'd0);
    nes.latchOrange = 1'b0;
    wait_cycles(SETTLE);
    buttons = 8'h00;
    wait_cycles(SETTLE);
    check("frozen_bit0", {31'd0, nes.dataYellow}, 32'd0);
    clk_pulse();
    check("frozen_bit1", {31'd0, nes.dataYellow}, 32'd1);

    // Abort after 3 clock pulses
    buttons = 8'h08;
    s0 = strobe_cnt;
    latch_pulse();
    for (int k = 0; k < 3; k++) clk_pulse();
    check("abort_bit3", {31'd0, nes.dataYellow}, 32'd0);
    buttons = 8'h01;
    latch_pulse();
    check("abort_new_bit0", {31'd0, nes.dataYellow}, 32'd0);
    clk_pulse();
    check("abort_new_bit1", {31'd0, nes.dataYellow}, 32'd1);
    clk_pulse();
    clk_pulse();
    check("abort_new_bit3", {31'd0, nes.dataYellow}, 32'd1);
    check("abort_strobes", strobe_cnt - s0, 32'd2);

    // Latch and clock rise together mid-shift: latch wins
    buttons = 8'h00;
    latch_pulse();
    check("coinc_pre_bit0", {31'd0, nes.dataYellow}, 32'd1);
    buttons = 8'h03;
    @(negedge clock);
    nes.latchOrange = 1'b1;
    nes.clockRed = 1'b1;
    wait_cycles(HALF);
    nes.clockRed = 1'b0;
    wait_cycles(LATCH_HOLD);
    nes.latchOrange = 1'b0;
    wait_cycles(SETTLE);
    check("coinc_bit0", {31'd0, nes.dataYellow}, 32'd0);
    clk_pulse();
    check("coinc_bit1", {31'd0, nes.dataYellow}, 32'd0);
    clk_pulse();
    check("coinc_bit2", {31'd0, nes.dataYellow}, 32'd1);

    // Reset mid-frame
    buttons = 8'h01;
    @(negedge clock);
    nes.latchOrange = 1'b1;
    wait_cycles(10);
    check("midrst_pre", {31'd0, nes.dataYellow}, 32'd0);
    reset = 1'b1;
    wait_cycles(1);
    check("midrst_data", {31'd0, nes.dataYellow}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_strobe", {31'd0, frameStrobe}, 32'd0);
    nes.latchOrange = 1'b0;
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(10);
    check("midrst_idle", {31'd0, nes.dataYellow}, 32'd1);

    // Turbo on A across 8 frames (TURBO_DIV = 2 on this instance)
    do_reset();
    buttons = 8'h01;
    turboA = 1'b1;
    for (int f = 0; f < 8; f++) begin
`ifdef NES_TURBO_EN
      turbo_exp = ((f / 2) % 2 == 1) ? 1'b1 : 1'b0;
`else
      turbo_exp = 1'b0;
`endif
      latch_pulse();
      check($sformatf("turbo_f%0d", f), {31'd0, nes.dataYellow}, {31'd0, turbo_exp});
    end
    turboA = 1'b0;

    check("strobe_width", strobe_wide, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
